// File: rtl/sync_dp_ram_if.sv
// Request/response bundle for sync_dp_ram: write port, read port and status.
// The master side issues requests; the slave side is the RAM itself.
interface sync_dp_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NBYTES-1:0]     wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/sync_dp_ram.sv
// Synchronous dual-port RAM with byte enables, write-first reads and a post-reset clear.
// Define SYNC_DP_RAM_OUTREG_EN to add a second output register (read latency 2).
module sync_dp_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  sync_dp_ram_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NBYTES-1:0]     be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  init_last;
  logic                  init_wr, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic                  vld_p0;

  assign init_last = (init_cnt == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_last) state_d = READY;
  end

  // Requests are only honoured in READY and never on a reset edge.
  always_comb begin
    bus.init_busy = (state_q == INIT);
    init_wr       = (state_q == INIT)  && !rst;
    wr_acc        = (state_q == READY) && !rst && bus.wr_en;
    rd_acc        = (state_q == READY) && !rst && bus.rd_en;
  end

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_cnt] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= merge_lanes(mem[bus.wr_addr], bus.wr_data, bus.wr_be);
    end
  end

  // Write-first: a same-edge write to the read address forwards its enabled lanes.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
      rd_word = merge_lanes(rd_word, bus.wr_data, bus.wr_be);
    end
  end

  // Stage p0: array read register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      rd_data_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) rd_data_p0 <= rd_word;
    end
  end

`ifdef SYNC_DP_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // Stage p1: extra output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) rd_data_p1 <= rd_data_p0;
    end
  end

  assign bus.rd_data  = rd_data_p1;
  assign bus.rd_valid = vld_p1;
`else
  assign bus.rd_data  = rd_data_p0;
  assign bus.rd_valid = vld_p0;
`endif
endmodule

// File: tb/tb_sync_dp_ram.sv
// Scoreboard bench for sync_dp_ram: a reference memory predicts each read and its due cycle.
// Works in both builds (SYNC_DP_RAM_OUTREG_EN selects expected latency 2).
module tb_sync_dp_ram;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** AW;
`ifdef SYNC_DP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_dp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();

  sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t          q[$];
  logic [DW-1:0] mdl [DEPTH];
  int            cyc    = 0;
  int            total  = 0;
  int            bad    = 0;
  bit            mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    logic ev;
    if (mon_on) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
      if (ev) begin
        chk("rd_data", 32'(bus.rd_data), 32'(q[0].data));
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
  endtask

  function automatic logic [DW-1:0] mdl_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    if (be[0]) r[7:0]  = n[7:0];
    if (be[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  // One bus cycle; acc says whether the RAM is expected to honour it.
  task automatic op(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [NB-1:0] be, input bit re, input logic [AW-1:0] ra, input bit acc);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_be   = be;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    if (acc) begin
      if (we) mdl[wa] = mdl_merge(mdl[wa], wd, be);
      if (re) q.push_back('{data: mdl[ra], due: cyc + LAT});
    end
    step();
    idle_bus();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    op(1'b1, a, d, be, 1'b0, '0, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    op(1'b0, '0, '0, '0, 1'b1, a, 1'b1);
  endtask

  // Reads still in flight when rst is sampled are discarded by the RAM.
  task automatic rst_pulse(input int n, input bit rd_during);
    idle_bus();
    rst = 1'b1;
    if (rd_during) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'h2;
    end
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    repeat (n) step();
    rst = 1'b0;
    idle_bus();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mon_on = 1'b1;
    chk("rst_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_vld", 32'(bus.rd_valid), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);
  endtask

  task automatic wait_init(input int n0);
    int n;
    n = n0;
    while (bus.init_busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("init_len", 32'(n), 32'd16);
  endtask

  task automatic drain();
    repeat (LAT + 2) step();
    chk("q_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_bus();
    step();
    rst_pulse(1, 1'b0);
    wait_init(0);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    drain();

    wr(4'h1, 16'hAABB, 2'b11);
    wr(4'h2, 16'hCCDD, 2'b11);
    wr(4'hF, 16'h1234, 2'b11);
    rd(4'h1);
    rd(4'h2);
    rd(4'hF);
    drain();
    chk("hold", 32'(bus.rd_data), 32'h1234);

    wr(4'h3, 16'h5566, 2'b11);
    wr(4'h3, 16'hFF00, 2'b01);
    rd(4'h3);

    wr(4'h4, 16'h1111, 2'b11);
    op(1'b1, 4'h4, 16'h2222, 2'b10, 1'b1, 4'h4, 1'b1);
    rd(4'h4);

    op(1'b1, 4'h5, 16'h7788, 2'b11, 1'b1, 4'h2, 1'b1);
    rd(4'h5);
    wr(4'h2, 16'hFFFF, 2'b00);
    rd(4'h2);
    drain();

    rst_pulse(1, 1'b0);
    repeat (4) step();
    op(1'b1, 4'h1, 16'hBEEF, 2'b11, 1'b1, 4'h1, 1'b0);
    wait_init(5);
    rd(4'h1);
    drain();

    rst_pulse(1, 1'b0);
    repeat (8) step();
    rst_pulse(3, 1'b0);
    wait_init(0);

    wr(4'h2, 16'h9ABC, 2'b11);
    rd(4'h2);
    rst_pulse(1, 1'b0);
    wait_init(0);
    rst_pulse(1, 1'b1);
    wait_init(0);
    rd(4'h2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_dp_ram.md
SYNC_DP_RAM -- requirements
Module: sync_dp_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one memory word in bits; SHALL be a multiple of BYTE_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter BYTE_WIDTH, default 8, bits per write-enable lane; NBYTES = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  write request for the current cycle.
REQ-007 wr_addr  input  ADDR_WIDTH  write address.
REQ-008 wr_data  input  DATA_WIDTH  write data.
REQ-009 wr_be  input  NBYTES  per-lane write enable; bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-010 rd_en  input  1  read request for the current cycle.
REQ-011 rd_addr  input  ADDR_WIDTH  read address.
REQ-012 rd_data  output  DATA_WIDTH  registered read data.
REQ-013 rd_valid  output  1  one-cycle strobe: rd_data holds a new read result.
REQ-014 init_busy  output  1  high while the post-reset clear sequence runs; requests are ignored.

Function
REQ-015 FSM states: INIT and READY; a reset edge SHALL force INIT with init counter = 0.
REQ-016 INIT SHALL write all-zero to address init counter each cycle, incrementing by 1, covering 0..DEPTH-1 in exactly DEPTH cycles.
REQ-017 When INIT writes address DEPTH-1, the FSM SHALL go to READY on that same edge; init_busy SHALL be low from the next cycle.
REQ-018 In INIT, wr_en and rd_en SHALL be ignored: no memory change, rd_valid stays 0.
REQ-019 In READY, wr_en=1 SHALL update only the lanes with wr_be[i]=1 at wr_addr; wr_be=0 SHALL leave memory unchanged.
REQ-020 In READY, rd_en=1 at edge N SHALL give rd_data = mem[rd_addr] and rd_valid=1 after edge N+1 (latency 1, without SYNC_DP_RAM_OUTREG_EN).
REQ-021 rd_valid SHALL be 0 in any cycle following an edge with no accepted read; rd_data SHALL hold its last value.
REQ-022 Same-edge read and write to the same address SHALL be write-first: enabled lanes return wr_data, disabled lanes return old memory contents.
REQ-023 Same-edge read and write to different addresses SHALL both complete independently with no interference.
REQ-024 Back-to-back reads on consecutive edges SHALL give one result per cycle with no bubbles.

Reset
REQ-025 After a reset edge: rd_data = 0, rd_valid = 0, init_busy = 1, FSM = INIT, init counter = 0.
REQ-026 Reset asserted mid-INIT or mid-read SHALL restart INIT from address 0 and discard in-flight reads, with no rd_valid pulse.
REQ-027 Holding rst high for multiple cycles SHALL keep the block in the reset state; INIT counting SHALL begin on the first edge with rst low.

Configuration
REQ-028 Macro SYNC_DP_RAM_OUTREG_EN defined: one extra output register stage; read latency 2 (rd_en at edge N gives rd_valid/rd_data after N+2); both stages reset to 0; a read issued during a reset is discarded.
REQ-029 Macro SYNC_DP_RAM_OUTREG_EN undefined: latency 1 exactly as REQ-020; all other behaviour identical in both builds.

Verification (defaults DATA_WIDTH=16, ADDR_WIDTH=4, BYTE_WIDTH=8)
REQ-030 Pulse rst 1 cycle, then idle -> init_busy high for exactly 16 cycles; then read every address -> every result 16'h0000.
REQ-031 After init, write 0x1 <- 16'hAABB, 0x2 <- 16'hCCDD, 0xF <- 16'h1234 (wr_be=2'b11); read 0x1, 0x2, 0xF back-to-back -> rd_valid high 3 consecutive cycles, data AABB, CCDD, 1234.
REQ-032 Write 0x3 <- 16'h5566 with be=11, then write 0x3 <- 16'hFF00 with be=01 -> read 0x3 returns 16'h5500.
REQ-033 With mem[0x4]=16'h1111, same-edge write 0x4 <- 16'h2222 with be=10 and read 0x4 -> rd_data 16'h2211; then read 0x4 -> 16'h2211.
REQ-034 Request a write and a read during INIT (cycle 5) -> rd_valid stays 0; after init the target address reads 16'h0000.
REQ-035 Assert rst at INIT cycle 8 and again on the edge after a rd_en -> no rd_valid pulse; init_busy stays high for 16 full cycles after rst drops; repeat REQ-031 with SYNC_DP_RAM_OUTREG_EN defined -> latency 2.
